exec_control_unit: RTL and testbench
====================================

Name: exec_control_unit

Overview:
- Multi-cycle instruction sequencer that drives the execute unit's 3-bit function select.
- Accepts 16-bit instructions over a valid/ready handshake and decodes them.
- Steps each instruction through DECODE/EXECUTE/WRITEBACK, issuing register-file read/write controls and a program counter.
- Sits between the instruction source and the execute/register-file datapath; it is the control side of the execute_fs interface.

Parameters:
- PC_W, 8, width of the program counter (wraps modulo 2^PC_W).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- instr_valid  input  1  instruction source has an instruction on instr.
- instr  input  16  instruction: [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt.
- instr_ready  output  1  controller can accept an instruction.
- execute_fs  output  3  execute function select: 0 zero, 1 A+B, 2 A-B, 3 pass B, 4 B+1.
- rf_raddr_a  output  4  register-file read address feeding execute in_A.
- rf_raddr_b  output  4  register-file read address feeding execute in_B.
- rf_we  output  1  register-file write enable; writes execute out.
- rf_waddr  output  4  register-file write address.
- pc  output  PC_W  count of retired or discarded instructions.
- busy  output  1  high in DECODE, EXECUTE and WRITEBACK.
- halted  output  1  high in HALT state.
- illegal  output  1  sticky; set on an undefined opcode.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: while rst_n=0, all outputs are 0 and state=IDLE; IR=0; pc=0; illegal=0. Assertion mid-instruction aborts immediately with no rf_we pulse.
- Opcodes:
  - 0x0 NOP.
  - 0x1 ADD rd=rs+rt, fs=1.
  - 0x2 SUB rd=rs-rt, fs=2.
  - 0x3 MOV rd=rt, fs=3.
  - 0x4 INC rd=rt+1, fs=4.
  - 0x5 CLR rd=0, fs=0.
  - 0xF HALT.
  - 0x6-0xE illegal.
- States: IDLE, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - instr_ready=1.
  - When instr_valid && instr_ready at a clock edge: capture instr into IR and go to DECODE.
  - Without instr_valid: remain in IDLE.
  - instr is ignored whenever instr_ready=0.
- DECODE:
  - rf_raddr_a=IR[7:4], rf_raddr_b=IR[3:0].
  - NOP: pc+1, go to IDLE.
  - Illegal opcode: illegal<=1, pc+1, go to IDLE.
  - HALT: pc+1, go to HALT.
  - ALU opcodes: go to EXECUTE.
- EXECUTE: execute_fs=decoded code; read addresses held. One cycle for the combinational datapath to settle.
- WRITEBACK:
  - execute_fs and read addresses unchanged from EXECUTE.
  - rf_we=1 for exactly this cycle; rf_waddr=IR[11:8].
  - Next state IDLE; pc+1.
- Outside EXECUTE/WRITEBACK: execute_fs=0; rf_we=0; rf_waddr=0.
- Read addresses: 0 in IDLE and HALT.
- Latency from accept edge:
  - ALU op: 3 cycles to return to IDLE; rf_we is high in the 3rd cycle after accept.
  - NOP/illegal: 1 cycle.
  - Throughput: 1 ALU instruction per 4 cycles.
- pc: increments exactly once per instruction, on the transition that leaves the instruction; wraps from 2^PC_W-1 to 0 with no flag.
- HALT: instr_ready=0, halted=1, no further state change until rst_n=0.
- illegal: stays 1 until reset; it does not stop execution.
- Outputs:
  - State-derived outputs (instr_ready, busy, halted, rf_*, execute_fs) are decoded combinationally from registered state/IR.
  - pc and illegal are registered.

Test Plan:
- Reset and idle: rst_n=0 for 2 cycles, release, instr_valid=0 for 5 cycles -> instr_ready=1, busy=0, pc=0, execute_fs=0, rf_we=0 throughout.
- ADD: instr=0x1312 accepted at edge T.
  - DECODE at T+1 shows rf_raddr_a=1, rf_raddr_b=2.
  - EXECUTE at T+2 shows execute_fs=1.
  - WRITEBACK at T+3 shows rf_we=1, rf_waddr=3, execute_fs=1.
  - IDLE at T+4 shows pc=1.
- Back-to-back: instr_valid held high with SUB 0x2412, MOV 0x3505, INC 0x4606, CLR 0x5700.
  - instr_ready is 0 for 3 cycles after each accept.
  - fs sequence is 2, 3, 4, 0.
  - waddr sequence is 4, 5, 6, 7.
  - pc=4 after the last.
- NOP and illegal: 0x0000 then 0x9ABC.
  - Each returns to IDLE after 1 busy cycle with no rf_we.
  - illegal=1 after 0x9ABC and stays 1; pc=2.
- HALT and wrap: PC_W=2.
  - Issue 3 NOPs then 0xF000 -> pc wraps 3->0 on HALT.
  - halted=1, instr_ready=0; further instr_valid is ignored for 10 cycles.
- Async reset mid-op: assert rst_n=0 mid-cycle during EXECUTE of 0x1312.
  - Outputs go to 0 before the next clock edge.
  - No rf_we pulse; state=IDLE after release.

Source files
------------

// File: rtl/exec_control_unit.sv
// Multi-cycle instruction sequencer driving the execute unit's function select.
// Instructions arrive over a valid/ready handshake and are stepped through
// DECODE, EXECUTE and WRITEBACK, issuing register-file controls and a
// retired-instruction counter.
module exec_control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic            instr_ready,
    output logic [2:0]      execute_fs,
    output logic [3:0]      rf_raddr_a,
    output logic [3:0]      rf_raddr_b,
    output logic            rf_we,
    output logic [3:0]      rf_waddr,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     ir_q, ir_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            illegal_q, illegal_d;
    logic [3:0]      opcode;
    logic [2:0]      fs_code;

    assign opcode = ir_q[15:12];

    // Map the held opcode onto the execute function select; CLR selects zero.
    always_comb begin
        fs_code = 3'd0;
        case (opcode)
            4'h1:    fs_code = 3'd1;
            4'h2:    fs_code = 3'd2;
            4'h3:    fs_code = 3'd3;
            4'h4:    fs_code = 3'd4;
            default: fs_code = 3'd0;
        endcase
    end

    // State, instruction register, counter and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; pc advances on the transition that leaves an instruction.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    4'h0: begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_IDLE;
                    end
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        state_d = S_EXECUTE;
                    end
                    4'hF: begin
                        pc_d    = pc_q + 1'b1;
                        state_d = S_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        pc_d      = pc_q + 1'b1;
                        state_d   = S_IDLE;
                    end
                endcase
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath controls decoded from the registered state and instruction.
    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        execute_fs  = 3'd0;
        rf_raddr_a  = 4'd0;
        rf_raddr_b  = 4'd0;
        rf_we       = 1'b0;
        rf_waddr    = 4'd0;
        case (state_q)
            S_IDLE: begin
                instr_ready = rst_n;
            end
            S_DECODE: begin
                busy       = 1'b1;
                rf_raddr_a = ir_q[7:4];
                rf_raddr_b = ir_q[3:0];
            end
            S_EXECUTE: begin
                busy       = 1'b1;
                rf_raddr_a = ir_q[7:4];
                rf_raddr_b = ir_q[3:0];
                execute_fs = fs_code;
            end
            S_WRITEBACK: begin
                busy       = 1'b1;
                rf_raddr_a = ir_q[7:4];
                rf_raddr_b = ir_q[3:0];
                execute_fs = fs_code;
                rf_we      = 1'b1;
                rf_waddr   = ir_q[11:8];
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign pc      = pc_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_exec_control_unit.sv
// Directed testbench for exec_control_unit: reset, ALU sequencing,
// back-to-back issue, NOP/illegal handling, async abort, HALT and pc wrap.
module tb_exec_control_unit;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;

    logic        instr_ready, rf_we, busy, halted, illegal;
    logic [2:0]  execute_fs;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [7:0]  pc;

    logic        instr_ready2, rf_we2, busy2, halted2, illegal2;
    logic [2:0]  execute_fs2;
    logic [3:0]  rf_raddr_a2, rf_raddr_b2, rf_waddr2;
    logic [1:0]  pc2;

    int checks;
    int failures;

    exec_control_unit #(.PC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .execute_fs(execute_fs),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .pc(pc),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    exec_control_unit #(.PC_W(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready2), .execute_fs(execute_fs2),
        .rf_raddr_a(rf_raddr_a2), .rf_raddr_b(rf_raddr_b2),
        .rf_we(rf_we2), .rf_waddr(rf_waddr2), .pc(pc2),
        .busy(busy2), .halted(halted2), .illegal(illegal2)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] word);
        instr_valid = v;
        instr       = word;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 16'h0000);

        // Reset held for two cycles: every output low.
        tick();
        tick();
        checkOutput("rst_ready", {31'd0, instr_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_pc", {24'd0, pc}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        // Idle with no valid instruction for five cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_ready", {31'd0, instr_ready}, 32'd1);
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
            checkOutput("idle_pc", {24'd0, pc}, 32'd0);
            checkOutput("idle_fs", {29'd0, execute_fs}, 32'd0);
            checkOutput("idle_we", {31'd0, rf_we}, 32'd0);
        end

        // ADD r3 = r1 + r2.
        applyStimulus(1'b1, 16'h1312);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("add_dec_busy", {31'd0, busy}, 32'd1);
        checkOutput("add_dec_ra", {28'd0, rf_raddr_a}, 32'd1);
        checkOutput("add_dec_rb", {28'd0, rf_raddr_b}, 32'd2);
        checkOutput("add_dec_fs", {29'd0, execute_fs}, 32'd0);
        checkOutput("add_dec_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        checkOutput("add_ex_fs", {29'd0, execute_fs}, 32'd1);
        checkOutput("add_ex_we", {31'd0, rf_we}, 32'd0);
        tick();
        checkOutput("add_wb_we", {31'd0, rf_we}, 32'd1);
        checkOutput("add_wb_waddr", {28'd0, rf_waddr}, 32'd3);
        checkOutput("add_wb_fs", {29'd0, execute_fs}, 32'd1);
        checkOutput("add_wb_ra", {28'd0, rf_raddr_a}, 32'd1);
        tick();
        checkOutput("add_idle_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("add_idle_we", {31'd0, rf_we}, 32'd0);
        checkOutput("add_idle_pc", {24'd0, pc}, 32'd1);

        // Back-to-back SUB, MOV, INC, CLR with valid held high.
        begin
            logic [15:0] words [4];
            logic [2:0]  fsExp [4];
            logic [3:0]  waExp [4];
            words[0] = 16'h2412; fsExp[0] = 3'd2; waExp[0] = 4'd4;
            words[1] = 16'h3505; fsExp[1] = 3'd3; waExp[1] = 4'd5;
            words[2] = 16'h4606; fsExp[2] = 3'd4; waExp[2] = 4'd6;
            words[3] = 16'h5700; fsExp[3] = 3'd0; waExp[3] = 4'd7;
            for (int k = 0; k < 4; k++) begin
                applyStimulus(1'b1, words[k]);
                tick();
                checkOutput("b2b_dec_ready", {31'd0, instr_ready}, 32'd0);
                tick();
                checkOutput("b2b_ex_ready", {31'd0, instr_ready}, 32'd0);
                checkOutput("b2b_ex_fs", {29'd0, execute_fs}, {29'd0, fsExp[k]});
                tick();
                checkOutput("b2b_wb_ready", {31'd0, instr_ready}, 32'd0);
                checkOutput("b2b_wb_we", {31'd0, rf_we}, 32'd1);
                checkOutput("b2b_wb_fs", {29'd0, execute_fs}, {29'd0, fsExp[k]});
                checkOutput("b2b_wb_waddr", {28'd0, rf_waddr}, {28'd0, waExp[k]});
                tick();
                checkOutput("b2b_idle_ready", {31'd0, instr_ready}, 32'd1);
                checkOutput("b2b_idle_pc", {24'd0, pc}, 32'd2 + k);
            end
            applyStimulus(1'b0, 16'h0000);
        end
        checkOutput("b2b_pc_final", {24'd0, pc}, 32'd5);

        // NOP: one busy cycle, no write.
        applyStimulus(1'b1, 16'h0000);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("nop_busy", {31'd0, busy}, 32'd1);
        checkOutput("nop_we", {31'd0, rf_we}, 32'd0);
        tick();
        checkOutput("nop_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("nop_pc", {24'd0, pc}, 32'd6);
        checkOutput("nop_illegal", {31'd0, illegal}, 32'd0);

        // Illegal opcode 0x9: one busy cycle, sticky flag set.
        applyStimulus(1'b1, 16'h9ABC);
        tick();
        applyStimulus(1'b0, 16'h0000);
        checkOutput("ill_busy", {31'd0, busy}, 32'd1);
        checkOutput("ill_we", {31'd0, rf_we}, 32'd0);
        tick();
        checkOutput("ill_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("ill_flag", {31'd0, illegal}, 32'd1);
        checkOutput("ill_pc", {24'd0, pc}, 32'd7);
        tick();
        tick();
        checkOutput("ill_sticky", {31'd0, illegal}, 32'd1);

        // Async reset during EXECUTE of ADD aborts without a write.
        applyStimulus(1'b1, 16'h1312);
        tick();
        applyStimulus(1'b0, 16'h0000);
        tick();
        checkOutput("abort_pre_fs", {29'd0, execute_fs}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_fs", {29'd0, execute_fs}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_we", {31'd0, rf_we}, 32'd0);
        checkOutput("abort_pc", {24'd0, pc}, 32'd0);
        checkOutput("abort_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("abort_ready", {31'd0, instr_ready}, 32'd0);
        tick();
        checkOutput("abort_edge_we", {31'd0, rf_we}, 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("abort_rel_ready", {31'd0, instr_ready}, 32'd1);
        checkOutput("abort_rel_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_rel_we", {31'd0, rf_we}, 32'd0);

        // Narrow counter: three NOPs then HALT wraps pc 3 -> 0.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b1, 16'h0000);
            tick();
            applyStimulus(1'b0, 16'h0000);
            tick();
        end
        checkOutput("wrap_pc3", {30'd0, pc2}, 32'd3);
        applyStimulus(1'b1, 16'hF000);
        tick();
        applyStimulus(1'b1, 16'h1312);
        tick();
        checkOutput("halt_flag", {31'd0, halted2}, 32'd1);
        checkOutput("halt_ready", {31'd0, instr_ready2}, 32'd0);
        checkOutput("halt_pc_wrap", {30'd0, pc2}, 32'd0);
        checkOutput("halt_pc_wide", {24'd0, pc}, 32'd4);
        for (int h = 0; h < 10; h++) begin
            tick();
            checkOutput("halt_hold", {31'd0, halted2}, 32'd1);
            checkOutput("halt_nobusy", {31'd0, busy2}, 32'd0);
            checkOutput("halt_nowe", {31'd0, rf_we2}, 32'd0);
        end
        checkOutput("halt_pc_hold", {30'd0, pc2}, 32'd0);
        applyStimulus(1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
